// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enable RAM with hardware clear.
package ram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  function automatic int unsigned byte_lanes(input int unsigned m);
    return m / 8;
  endfunction

endpackage

// File: rtl/ram_be_array.sv
// Pure storage: 2^N x M words, per-byte write enable, registered read-first port, no reset.
module ram_be_array
  import ram_pkg::*;
#(
  parameter int unsigned N = 6,
  parameter int unsigned M = 32
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [byte_lanes(M)-1:0]   be,
  input  logic [N-1:0]               addr,
  input  logic [M-1:0]               wdata,
  input  logic                       re,
  output logic [M-1:0]               rdata
);

  localparam int unsigned DEPTH = 2 ** N;
  localparam int unsigned BL    = byte_lanes(M);

  logic [M-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
    for (int i = 0; i < BL; i++) begin
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/ram_be_clr.sv
// Single-port byte-enable RAM with valid/ready requests, 1- or 2-cycle read latency
// and a clear engine that zeroes the whole array after reset or on clr_start.
module ram_be_clr
  import ram_pkg::*;
#(
  parameter int unsigned N          = 6,
  parameter int unsigned M          = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [N-1:0]             req_addr,
  input  logic [M-1:0]             req_wdata,
  input  logic [byte_lanes(M)-1:0] req_be,
  output logic                     rsp_valid,
  output logic [M-1:0]             rsp_rdata,
  input  logic                     clr_start,
  output logic                     busy
);

  localparam int unsigned DEPTH = 2 ** N;
  localparam int unsigned BL    = byte_lanes(M);
  localparam int unsigned CW    = N + 1;
  localparam ram_state_e  RST_STATE = (INIT_CLEAR != 0) ? CLEAR : READY;

  if ((M % 8) != 0 || M == 0) begin : g_bad_m
    $error("ram_be_clr: M must be a non-zero multiple of 8");
  end
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("ram_be_clr: RD_LAT must be 1 or 2");
  end

  ram_state_e    state, state_nxt;
  logic [CW-1:0] clr_addr, clr_addr_nxt;

  logic          accept;
  logic          arr_we;
  logic          arr_re;
  logic [BL-1:0] arr_be;
  logic [N-1:0]  arr_addr;
  logic [M-1:0]  arr_wdata;
  logic [M-1:0]  arr_rdata;

  assign accept = req_valid && req_ready;

  // Next state and write-port mux: the clear engine owns the port while in CLEAR.
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    arr_we       = 1'b0;
    arr_re       = 1'b0;
    arr_be       = req_be;
    arr_addr     = req_addr;
    arr_wdata    = req_wdata;
    unique case (state)
      CLEAR: begin
        arr_we       = 1'b1;
        arr_be       = '1;
        arr_addr     = clr_addr[N-1:0];
        arr_wdata    = '0;
        clr_addr_nxt = clr_addr + CW'(1);
        if (clr_addr == CW'(DEPTH - 1)) begin
          state_nxt    = READY;
          clr_addr_nxt = '0;
        end
      end
      READY: begin
        arr_we = accept && req_we;
        arr_re = accept && !req_we;
        if (clr_start) begin
          state_nxt    = CLEAR;
          clr_addr_nxt = '0;
        end
      end
    endcase
  end

  // State, clear counter and the state-decoded handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RST_STATE;
      clr_addr  <= '0;
      req_ready <= (INIT_CLEAR == 0);
      busy      <= (INIT_CLEAR != 0);
    end else begin
      state     <= state_nxt;
      clr_addr  <= clr_addr_nxt;
      req_ready <= (state_nxt == READY);
      busy      <= (state_nxt == CLEAR);
    end
  end

  ram_be_array #(
    .N (N),
    .M (M)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (arr_be),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .rdata (arr_rdata)
  );

  if (RD_LAT == 1) begin : g_lat1
    // The array's read register is the response; gate it to zero until a read has landed since reset.
    logic seen;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rsp_valid <= 1'b0;
        seen      <= 1'b0;
      end else begin
        rsp_valid <= arr_re;
        if (arr_re) seen <= 1'b1;
      end
    end
    assign rsp_rdata = seen ? arr_rdata : '0;
  end else begin : g_lat2
    logic v1;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v1        <= 1'b0;
        rsp_valid <= 1'b0;
        rsp_rdata <= '0;
      end else begin
        v1        <= arr_re;
        rsp_valid <= v1;
        if (v1) rsp_rdata <= arr_rdata;
      end
    end
  end

endmodule
